// File: rtl/param_width_serializer_if.sv
// Handshake and serial-link signals of the parallel-to-serial transmitter.
// master = word source / link observer, slave = the serializer itself.
interface param_width_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ser_out,
        output ser_valid,
        output ser_last,
        output busy
    );
endinterface

// File: rtl/param_width_serializer.sv
// Parallel-to-serial transmitter: one WIDTH-bit word per frame, one bit per clock.
// Defining SER_PARITY_EN appends an even-parity beat that carries ser_last instead.
module param_width_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    param_width_serializer_if.slave bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
    localparam bit LAST_ON_DATA = 1'b0;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    localparam bit LAST_ON_DATA = 1'b1;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_word;
    logic [CW-1:0]    r_cnt;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_ser_last;
    logic             r_busy;

    logic [WIDTH-1:0] w_ord_in;
    logic [CW-1:0]    w_cnt_next;
    logic             w_last_data;
    logic             w_in_ready;
    logic             w_accept;

    // The word is stored in transmission order, so beat k always sends r_word[k].
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_order
            if (LSB_FIRST) begin : g_lsb
                assign w_ord_in[gi] = bus.in_data[gi];
            end else begin : g_msb
                assign w_ord_in[gi] = bus.in_data[WIDTH-1-gi];
            end
        end
    endgenerate

`ifdef SER_PARITY_EN
    logic [WIDTH:0] w_par_chain;
    assign w_par_chain[0] = 1'b0;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_parity
            assign w_par_chain[gi+1] = w_par_chain[gi] ^ r_word[gi];
        end
    endgenerate
`endif

    assign w_cnt_next  = r_cnt + 1'b1;
    assign w_last_data = (r_state == SHIFT) && (r_cnt == LAST_IDX);

    // Ready on the final beat lets the next word follow with no gap cycle.
`ifdef SER_PARITY_EN
    assign w_in_ready = (r_state == IDLE) || (r_state == PARITY);
`else
    assign w_in_ready = (r_state == IDLE) || w_last_data;
`endif
    assign w_accept = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_cnt       <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            r_state     <= SHIFT;
            r_word      <= w_ord_in;
            r_cnt       <= '0;
            r_ser_out   <= w_ord_in[0];
            r_ser_valid <= 1'b1;
            r_ser_last  <= LAST_ON_DATA && (WIDTH == 1);
            r_busy      <= 1'b1;
        end else if ((r_state == SHIFT) && !w_last_data) begin
            r_cnt      <= w_cnt_next;
            r_ser_out  <= r_word[w_cnt_next];
            r_ser_last <= LAST_ON_DATA && (w_cnt_next == LAST_IDX);
`ifdef SER_PARITY_EN
        end else if (w_last_data) begin
            r_state    <= PARITY;
            r_ser_out  <= w_par_chain[WIDTH];
            r_ser_last <= 1'b1;
`endif
        end else begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_busy      <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.ser_out   = r_ser_out;
    assign bus.ser_valid = r_ser_valid;
    assign bus.ser_last  = r_ser_last;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_param_width_serializer.sv
// Directed bench for param_width_serializer: WIDTH=4 LSB-first, WIDTH=8 MSB-first, WIDTH=1.
// Expected streams are written out by hand in transmission order; SER_PARITY_EN adds the parity beat.
module tb_param_width_serializer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    always #5 clk = ~clk;

    param_width_serializer_if #(.WIDTH(4)) b4 ();
    param_width_serializer_if #(.WIDTH(8)) b8 ();
    param_width_serializer_if #(.WIDTH(1)) b1 ();

    param_width_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_w4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    param_width_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    param_width_serializer #(.WIDTH(1), .LSB_FIRST(1'b1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst_n = 1'b0;
        b4.in_valid = 1'b0; b4.in_data = '0;
        b8.in_valid = 1'b0; b8.in_data = '0;
        b1.in_valid = 1'b0; b1.in_data = '0;
        tick();
        tick();
        obs = {b4.ser_out, b4.ser_valid, b4.ser_last, b4.busy, b4.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL reset_held_w4 got=%b want=00001", obs); end
        obs = {b8.ser_out, b8.ser_valid, b8.ser_last, b8.busy, b8.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL reset_held_w8 got=%b want=00001", obs); end
        rst_n = 1'b1;
        tick();
        obs = {b4.ser_out, b4.ser_valid, b4.ser_last, b4.busy, b4.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL reset_rel_w4 got=%b want=00001", obs); end
        obs = {b8.ser_out, b8.ser_valid, b8.ser_last, b8.busy, b8.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL reset_rel_w8 got=%b want=00001", obs); end
        obs = {b1.ser_out, b1.ser_valid, b1.ser_last, b1.busy, b1.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL reset_rel_w1 got=%b want=00001", obs); end
        $display("reset: outputs idle, in_ready=1 on all instances");
    endtask

    // W4 LSB-first 4'b1010 -> 0,1,0,1 (parity 0)
    task automatic test_single();
        logic [0:4] s = 5'b01010;
        logic [4:0] obs, exp;
        logic       lst;
        b4.in_data  = 4'b1010;
        b4.in_valid = 1'b1;
        checks++;
        if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_idle got=%b want=1", b4.in_ready); end
        tick();
        b4.in_valid = 1'b0;
        b4.in_data  = 4'b0110;
        for (int k = 0; k < 4 + PAR; k++) begin
            lst = (k == 3 + PAR);
            exp = {s[k], 1'b1, lst, 1'b1, lst};
            obs = {b4.ser_out, b4.ser_valid, b4.ser_last, b4.busy, b4.in_ready};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL single_beat%0d got=%b want=%b", k, obs, exp); end
            tick();
        end
        obs = {b4.ser_out, b4.ser_valid, b4.ser_last, b4.busy, b4.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL single_end got=%b want=00001", obs); end
        $display("single: W4 word 1010 sent");
    endtask

    // W8 MSB-first 11001010 then 00110101, second held pending until the final beat
    task automatic test_back_to_back();
        logic [0:15] d = 16'b1100101000110101;
        logic [0:1]  p = 2'b00;
        logic [4:0]  obs, exp;
        logic        lst, bit_exp;
        b8.in_data  = 8'b11001010;
        b8.in_valid = 1'b1;
        tick();
        b8.in_data = 8'b00110101;
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 8 + PAR; b++) begin
                if (f == 1 && b == 0) b8.in_valid = 1'b0;
                lst     = (b == 7 + PAR);
                bit_exp = (b < 8) ? d[f*8 + b] : p[f];
                exp = {bit_exp, 1'b1, lst, 1'b1, lst};
                obs = {b8.ser_out, b8.ser_valid, b8.ser_last, b8.busy, b8.in_ready};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL b2b_f%0d_b%0d got=%b want=%b", f, b, obs, exp); end
                tick();
            end
        end
        obs = {b8.ser_out, b8.ser_valid, b8.ser_last, b8.busy, b8.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL b2b_end got=%b want=00001", obs); end
        $display("back_to_back: W8 words CA,35 sent contiguously");
    endtask

    // W8 MSB-first 8'h3C in flight while in_data flips to 8'hFF with in_valid held
    task automatic test_backpressure();
        logic [0:15] d = 16'b0011110011111111;
        logic [0:1]  p = 2'b00;
        logic [4:0]  obs, exp;
        logic        lst, bit_exp;
        b8.in_data  = 8'h3C;
        b8.in_valid = 1'b1;
        tick();
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 8 + PAR; b++) begin
                if (f == 0 && b == 2) b8.in_data = 8'hFF;
                if (f == 1 && b == 0) b8.in_valid = 1'b0;
                lst     = (b == 7 + PAR);
                bit_exp = (b < 8) ? d[f*8 + b] : p[f];
                exp = {bit_exp, 1'b1, lst, 1'b1, lst};
                obs = {b8.ser_out, b8.ser_valid, b8.ser_last, b8.busy, b8.in_ready};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL bp_f%0d_b%0d got=%b want=%b", f, b, obs, exp); end
                tick();
            end
        end
        obs = {b8.ser_out, b8.ser_valid, b8.ser_last, b8.busy, b8.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL bp_end got=%b want=00001", obs); end
        $display("backpressure: W8 3C unchanged, FF taken on final beat");
    endtask

    // W8 MSB-first A5 aborted after 3 bits, then 81 from bit 0
    task automatic test_reset_mid_frame();
        logic [0:2] a = 3'b101;
        logic [0:8] s = 9'b100000010;
        logic [4:0] obs, exp;
        logic       lst;
        b8.in_data  = 8'hA5;
        b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            obs = {b8.ser_out, b8.ser_valid, b8.ser_last, b8.busy, b8.in_ready};
            exp = {a[k], 4'b1010};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL rmid_pre%0d got=%b want=%b", k, obs, exp); end
            if (k < 2) tick();
        end
        rst_n = 1'b0;
        tick();
        obs = {b8.ser_out, b8.ser_valid, b8.ser_last, b8.busy, b8.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL rmid_abort got=%b want=00001", obs); end
        rst_n = 1'b1;
        b8.in_data  = 8'h81;
        b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        for (int k = 0; k < 8 + PAR; k++) begin
            lst = (k == 7 + PAR);
            exp = {s[k], 1'b1, lst, 1'b1, lst};
            obs = {b8.ser_out, b8.ser_valid, b8.ser_last, b8.busy, b8.in_ready};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL rmid_81_b%0d got=%b want=%b", k, obs, exp); end
            tick();
        end
        obs = {b8.ser_out, b8.ser_valid, b8.ser_last, b8.busy, b8.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL rmid_end got=%b want=00001", obs); end
        $display("reset_mid_frame: A5 aborted, 81 sent cleanly");
    endtask

    // W1 streaming 1,0,1 with in_valid held continuously
    task automatic test_width1();
        logic [0:2] d = 3'b101;
        logic [4:0] obs, exp;
        logic       lst;
        b1.in_data  = d[0];
        b1.in_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 1 + PAR; b++) begin
                lst = (b == PAR);
                exp = {d[i], 1'b1, lst, 1'b1, lst};
                obs = {b1.ser_out, b1.ser_valid, b1.ser_last, b1.busy, b1.in_ready};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL w1_w%0d_b%0d got=%b want=%b", i, b, obs, exp); end
                if (lst && i < 2) b1.in_data = d[i+1];
                if (lst && i == 2) b1.in_valid = 1'b0;
                tick();
            end
        end
        obs = {b1.ser_out, b1.ser_valid, b1.ser_last, b1.busy, b1.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL w1_end got=%b want=00001", obs); end
        $display("width1: 3 single-beat frames streamed");
    endtask

    // W4 LSB-first 1011 -> 1,1,0,1 par 1; 1001 -> 1,0,0,1 par 0
    task automatic test_parity();
        logic [0:7] d = 8'b11011001;
        logic [0:1] p = 2'b10;
        logic [4:0] obs, exp;
        logic       lst, bit_exp;
        b4.in_data  = 4'b1011;
        b4.in_valid = 1'b1;
        tick();
        b4.in_data = 4'b1001;
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 4 + PAR; b++) begin
                if (f == 1 && b == 0) b4.in_valid = 1'b0;
                lst     = (b == 3 + PAR);
                bit_exp = (b < 4) ? d[f*4 + b] : p[f];
                exp = {bit_exp, 1'b1, lst, 1'b1, lst};
                obs = {b4.ser_out, b4.ser_valid, b4.ser_last, b4.busy, b4.in_ready};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL par_f%0d_b%0d got=%b want=%b", f, b, obs, exp); end
                tick();
            end
        end
        obs = {b4.ser_out, b4.ser_valid, b4.ser_last, b4.busy, b4.in_ready};
        checks++;
        if (obs !== 5'b00001) begin errors++; $display("FAIL par_end got=%b want=00001", obs); end
        $display("parity: W4 words 1011,1001 sent (parity beats=%0d)", PAR);
    endtask

    initial begin
        b4.in_valid = 1'b0; b4.in_data = '0;
        b8.in_valid = 1'b0; b8.in_data = '0;
        b1.in_valid = 1'b0; b1.in_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_width1();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
